// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for a 4-digit common-anode seven-
//               segment display. Captures four hex nibbles plus decimal-point
//               mask on a load strobe, then scans one digit at a time with
//               hex decode and optional leading-zero blanking. All display
//               outputs are registered and active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int DIGIT_CYCLES = 100000,
  parameter int CNT_W        = $clog2(DIGIT_CYCLES)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_mask,
  input  logic       blank_zeros,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DIGIT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [15:0]      r_hold;   // {h3, h2, h1, h0}
  logic [3:0]       r_hdp;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic             w_wrap;
  logic [3:0]       w_nib;
  logic [6:0]       w_dec;
  logic [3:0]       w_zero;
  logic [3:0]       w_blank;
  logic             w_blank_sel;
  logic [3:0]       w_an_lit;

  assign w_wrap = (r_cnt == c_CNT_MAX);

  // Refresh counter and digit index; the index advances on the wrap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Holding registers; reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hold <= 16'h0000;
      r_hdp  <= 4'b0000;
    end else if (load) begin
      r_hold <= {d3, d2, d1, d0};
      r_hdp  <= dp_mask;
    end
  end

  // Digit select, hex decode (active-low g..a) and leading-zero blanking.
  always_comb begin
    w_nib = r_hold[{r_idx, 2'b00} +: 4];
    w_dec = 7'h7F;
    case (w_nib)
      4'h0: w_dec = 7'h40;
      4'h1: w_dec = 7'h79;
      4'h2: w_dec = 7'h24;
      4'h3: w_dec = 7'h30;
      4'h4: w_dec = 7'h19;
      4'h5: w_dec = 7'h12;
      4'h6: w_dec = 7'h02;
      4'h7: w_dec = 7'h78;
      4'h8: w_dec = 7'h00;
      4'h9: w_dec = 7'h10;
      4'hA: w_dec = 7'h08;
      4'hB: w_dec = 7'h03;
      4'hC: w_dec = 7'h46;
      4'hD: w_dec = 7'h21;
      4'hE: w_dec = 7'h06;
      4'hF: w_dec = 7'h0E;
      default: w_dec = 7'h7F;
    endcase

    w_zero[3] = (r_hold[15:12] == 4'h0);
    w_zero[2] = (r_hold[11:8]  == 4'h0);
    w_zero[1] = (r_hold[7:4]   == 4'h0);
    w_zero[0] = (r_hold[3:0]   == 4'h0);

    // A digit is blanked only if it and every digit to its left are zero;
    // the rightmost digit always shows so "0" is displayed for a zero value.
    w_blank[3] = blank_zeros & w_zero[3];
    w_blank[2] = blank_zeros & w_zero[3] & w_zero[2];
    w_blank[1] = blank_zeros & w_zero[3] & w_zero[2] & w_zero[1];
    w_blank[0] = 1'b0;

    w_blank_sel = w_blank[r_idx];
    w_an_lit    = ~(4'b0001 << r_idx);
  end

  // Registered outputs so no input has a combinational path to the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else if (w_blank_sel) begin
      r_an  <= 4'b1111;
      r_seg <= 7'h7F;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_lit;
      r_seg <= w_dec;
      r_dp  <= ~r_hdp[r_idx];
    end
  end

  assign seg = r_seg;
  assign dp  = r_dp;
  assign an  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver with DIGIT_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] d3, d2, d1, d0;
  logic [3:0] dp_mask;
  logic       blank_zeros;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  seg7_scan_driver #(.DIGIT_CYCLES(DC)) dut (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .d3         (d3),
    .d2         (d2),
    .d1         (d1),
    .d0         (d0),
    .dp_mask    (dp_mask),
    .blank_zeros(blank_zeros),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;      // {d3,d2,d1,d0}
    logic [3:0]  dpm;
    logic        bz;
    logic [3:0]  blk;    // expected blanked slots
    logic [27:0] segs;   // expected {seg3,seg2,seg1,seg0}
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [3:0] ean,
                       input logic [6:0] eseg, input logic edp);
    checks++;
    if (an !== ean || seg !== eseg || dp !== edp) begin
      errors++;
      $display("FAIL %s (cyc %0d): got an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
               name, cyc, an, seg, dp, ean, eseg, edp);
    end
  endtask

  // Reset one cycle, then load on the first released edge (edge E1, cyc=1).
  task automatic start(input logic [15:0] v, input logic [3:0] m, input logic bz);
    {d3, d2, d1, d0} = v;
    dp_mask     = m;
    blank_zeros = bz;
    reset = 1'b1;
    load  = 1'b0;
    step();
    reset = 1'b0;
    load  = 1'b1;
    cyc   = 0;
    step();
    load  = 1'b0;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step();
  endtask

  initial begin
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    int         s;

    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b0000, {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{16'h3210, 4'b0101, 1'b0, 4'b0000, {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[2] = '{16'h7654, 4'b1010, 1'b0, 4'b0000, {7'h78, 7'h02, 7'h12, 7'h19}};
    vecs[3] = '{16'hBA98, 4'b0000, 1'b0, 4'b0000, {7'h03, 7'h08, 7'h10, 7'h00}};
    vecs[4] = '{16'hFEDC, 4'b1111, 1'b0, 4'b0000, {7'h0E, 7'h06, 7'h21, 7'h46}};
    vecs[5] = '{16'h0040, 4'b1111, 1'b1, 4'b1100, {7'h7F, 7'h7F, 7'h19, 7'h40}};
    vecs[6] = '{16'h0000, 4'b0000, 1'b1, 4'b1110, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
    vecs[7] = '{16'h0000, 4'b0000, 1'b0, 4'b0000, {7'h40, 7'h40, 7'h40, 7'h40}};
    vecs[8] = '{16'h0500, 4'b0000, 1'b1, 4'b1000, {7'h7F, 7'h12, 7'h40, 7'h40}};
    vecs[9] = '{16'h1000, 4'b0000, 1'b1, 4'b0000, {7'h79, 7'h40, 7'h40, 7'h40}};

    reset = 1'b1; load = 1'b0; blank_zeros = 1'b0;
    {d3, d2, d1, d0} = 16'h0000; dp_mask = 4'b0000;
    step();
    check("reset_state", 4'b1111, 7'h7F, 1'b1);
    step();

    // Table: one full frame per vector. After edge Ek the shown slot is
    // ((k-1)/4)%4; E1 still shows pre-load data so checking starts at E2.
    foreach (vecs[i]) begin
      start(vecs[i].d, vecs[i].dpm, vecs[i].bz);
      for (int k = 2; k <= 17; k++) begin
        step();
        s = ((k - 1) / DC) % 4;
        if (vecs[i].blk[s]) begin
          e_an = 4'b1111; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
          e_an  = 4'b1111;
          e_an[s] = 1'b0;
          e_seg = vecs[i].segs[s*7 +: 7];
          e_dp  = ~vecs[i].dpm[s];
        end
        check($sformatf("vec%0d_slot%0d", i, s), e_an, e_seg, e_dp);
      end
    end

    // Inputs ignored without load; mid-slot load; load on wrap edge.
    start(16'h1234, 4'b0000, 1'b0);
    {d3, d2, d1, d0} = 16'hFFFF;
    run_to(9);
    check("hold_no_load", 4'b1011, 7'h24, 1'b1);
    {d3, d2, d1, d0} = 16'h8888; load = 1'b1;
    step(); load = 1'b0;
    check("mid_load_same_cycle", 4'b1011, 7'h24, 1'b1);
    step(); check("mid_load_next", 4'b1011, 7'h00, 1'b1);
    step(); check("mid_load_slot_full", 4'b1011, 7'h00, 1'b1);
    step(); check("slot3_after_load", 4'b0111, 7'h00, 1'b1);
    run_to(15);
    {d3, d2, d1, d0} = 16'hAAA9; load = 1'b1;
    step(); load = 1'b0;
    check("wrap_load_old_slot", 4'b0111, 7'h00, 1'b1);
    step(); check("wrap_load_new_digit", 4'b1110, 7'h10, 1'b1);

    // blank_zeros is live with one cycle of latency.
    start(16'h0000, 4'b0000, 1'b1);
    run_to(13);
    check("blank_slot3", 4'b1111, 7'h7F, 1'b1);
    blank_zeros = 1'b0;
    step(); check("unblank_next_cycle", 4'b0111, 7'h40, 1'b1);

    // Reset held three cycles mid-scan.
    start(16'h1234, 4'b1111, 1'b0);
    run_to(10);
    reset = 1'b1;
    step(); check("rst_first_edge", 4'b1111, 7'h7F, 1'b1);
    step(); step(); check("rst_third_edge", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0; cyc = 0;
    for (int k = 1; k <= 4; k++) begin
      step(); check($sformatf("rst_release_d0_%0d", k), 4'b1110, 7'h40, 1'b1);
    end
    step(); check("rst_release_d1", 4'b1101, 7'h40, 1'b1);

    // Reset and load together: reset wins.
    reset = 1'b1; load = 1'b1; {d3, d2, d1, d0} = 16'hFFFF; dp_mask = 4'b1111;
    step(); check("rst_vs_load", 4'b1111, 7'h7F, 1'b1);
    reset = 1'b0; load = 1'b0;
    step(); check("rst_vs_load_rel1", 4'b1110, 7'h40, 1'b1);
    step(); check("rst_vs_load_rel2", 4'b1110, 7'h40, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
